// File: rtl/l2_arbiter_if.sv
// rtl/l2_arbiter_if.sv - L1_I/L1_D miss requests and L2 operation bus seen by the arbiter
interface l2_arbiter_if #(
    parameter int TNUM_2 = 18,
    parameter int INUM_2 = 8,
    parameter int DWIDTH = 512
);
    logic              read_I_L2;
    logic [TNUM_2-1:0] tag_I_L2;
    logic [INUM_2-1:0] index_I_L2;
    logic              read_D_L2;
    logic              write_D_L2;
    logic [TNUM_2-1:0] tag_D_L2;
    logic [INUM_2-1:0] index_D_L2;
    logic [TNUM_2-1:0] wb_tag_D_L2;
    logic [INUM_2-1:0] wb_index_D_L2;
    logic [DWIDTH-1:0] wb_data_D_L2;
    logic              ready_L2;
    logic              read_L2;
    logic              write_L2;
    logic [TNUM_2-1:0] tag_L2;
    logic [INUM_2-1:0] index_L2;
    logic [DWIDTH-1:0] wdata_L2;
    logic              ready_L2_I;
    logic              ready_L2_D;
    logic              busy;
    logic [15:0]       gnt_cnt_I;
    logic [15:0]       gnt_cnt_D;

    modport slave (
        input  read_I_L2, tag_I_L2, index_I_L2,
        input  read_D_L2, write_D_L2, tag_D_L2, index_D_L2,
        input  wb_tag_D_L2, wb_index_D_L2, wb_data_D_L2, ready_L2,
        output read_L2, write_L2, tag_L2, index_L2, wdata_L2,
        output ready_L2_I, ready_L2_D, busy, gnt_cnt_I, gnt_cnt_D
    );

    modport master (
        output read_I_L2, tag_I_L2, index_I_L2,
        output read_D_L2, write_D_L2, tag_D_L2, index_D_L2,
        output wb_tag_D_L2, wb_index_D_L2, wb_data_D_L2, ready_L2,
        input  read_L2, write_L2, tag_L2, index_L2, wdata_L2,
        input  ready_L2_I, ready_L2_D, busy, gnt_cnt_I, gnt_cnt_D
    );
endinterface

// File: rtl/l2_arbiter.sv
// rtl/l2_arbiter.sv - round-robin arbiter sharing one L2 port between L1_I and L1_D misses
module l2_arbiter #(
    parameter int TNUM_2 = 18,
    parameter int INUM_2 = 8,
    parameter int DWIDTH = 512
) (
    input  logic         clk,
    input  logic         nrst,
    l2_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, I_RD, D_WB, D_RD} state_t;

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              busy_q, busy_d;
    logic [TNUM_2-1:0] tag_q, tag_d;
    logic [INUM_2-1:0] index_q, index_d;
    logic [TNUM_2-1:0] rf_tag_q, rf_tag_d;
    logic [INUM_2-1:0] rf_index_q, rf_index_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [15:0]       gnt_cnt_I_q, gnt_cnt_I_d;
    logic [15:0]       gnt_cnt_D_q, gnt_cnt_D_d;
    logic              gnt_i, gnt_d;

    // last_d_q=1 means D was granted last, so I has priority on a tie
    assign gnt_i = bus.read_I_L2 && (!bus.read_D_L2 || last_d_q);
    assign gnt_d = bus.read_D_L2 && !gnt_i;

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        read_d      = read_q;
        write_d     = write_q;
        tag_d       = tag_q;
        index_d     = index_q;
        rf_tag_d    = rf_tag_q;
        rf_index_d  = rf_index_q;
        wdata_d     = wdata_q;
        gnt_cnt_I_d = gnt_cnt_I_q;
        gnt_cnt_D_d = gnt_cnt_D_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_i) begin
                    state_d     = I_RD;
                    last_d_d    = 1'b0;
                    read_d      = 1'b1;
                    tag_d       = bus.tag_I_L2;
                    index_d     = bus.index_I_L2;
                    gnt_cnt_I_d = gnt_cnt_I_q + {15'd0, gnt_cnt_I_q != 16'hFFFF};
                end else if (gnt_d) begin
                    last_d_d    = 1'b1;
                    rf_tag_d    = bus.tag_D_L2;
                    rf_index_d  = bus.index_D_L2;
                    gnt_cnt_D_d = gnt_cnt_D_q + {15'd0, gnt_cnt_D_q != 16'hFFFF};
                    if (bus.write_D_L2) begin
                        state_d = D_WB;
                        write_d = 1'b1;
                        tag_d   = bus.wb_tag_D_L2;
                        index_d = bus.wb_index_D_L2;
                        wdata_d = bus.wb_data_D_L2;
                    end else begin
                        state_d = D_RD;
                        read_d  = 1'b1;
                        tag_d   = bus.tag_D_L2;
                        index_d = bus.index_D_L2;
                    end
                end
            end
            I_RD, D_RD: begin
                if (bus.ready_L2) begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                end
            end
            D_WB: begin
                // write-back done: switch straight to the refill read, no L1 pulse
                if (bus.ready_L2) begin
                    state_d = D_RD;
                    write_d = 1'b0;
                    read_d  = 1'b1;
                    tag_d   = rf_tag_q;
                    index_d = rf_index_q;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            busy_q      <= 1'b0;
            tag_q       <= '0;
            index_q     <= '0;
            rf_tag_q    <= '0;
            rf_index_q  <= '0;
            wdata_q     <= '0;
            gnt_cnt_I_q <= '0;
            gnt_cnt_D_q <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            read_q      <= read_d;
            write_q     <= write_d;
            busy_q      <= busy_d;
            tag_q       <= tag_d;
            index_q     <= index_d;
            rf_tag_q    <= rf_tag_d;
            rf_index_q  <= rf_index_d;
            wdata_q     <= wdata_d;
            gnt_cnt_I_q <= gnt_cnt_I_d;
            gnt_cnt_D_q <= gnt_cnt_D_d;
        end
    end

    assign bus.read_L2    = read_q;
    assign bus.write_L2   = write_q;
    assign bus.tag_L2     = tag_q;
    assign bus.index_L2   = index_q;
    assign bus.wdata_L2   = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.gnt_cnt_I  = gnt_cnt_I_q;
    assign bus.gnt_cnt_D  = gnt_cnt_D_q;
    assign bus.ready_L2_I = bus.ready_L2 && (state_q == I_RD);
    assign bus.ready_L2_D = bus.ready_L2 && (state_q == D_RD);
endmodule

// File: tb/tb_l2_arbiter.sv
// tb/tb_l2_arbiter.sv - directed self-checking bench for l2_arbiter
module tb_l2_arbiter;
    logic clk;
    logic nrst;
    int   n_checks;
    int   n_errors;
    int   n_rdy_i;
    int   n_rdy_d;
    int   base_d;
    logic [511:0] line_a;
    logic [511:0] line_b;

    l2_arbiter_if #(.TNUM_2(18), .INUM_2(8), .DWIDTH(512)) bus ();

    l2_arbiter #(.TNUM_2(18), .INUM_2(8), .DWIDTH(512)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ready_L2_I) n_rdy_i++;
        if (bus.ready_L2_D) n_rdy_d++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // ready_L2 high for one cycle; checks the combinational L1 pulses, returns at the next negedge
    task automatic pulse_ready(input string tag, input logic exp_i, input logic exp_d);
        bus.ready_L2 = 1'b1;
        #1;
        check({tag, "_rdy_i"}, 64'(bus.ready_L2_I), 64'(exp_i));
        check({tag, "_rdy_d"}, 64'(bus.ready_L2_D), 64'(exp_d));
        @(negedge clk);
        bus.ready_L2 = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.read_I_L2     = 1'b0;
        bus.tag_I_L2      = '0;
        bus.index_I_L2    = '0;
        bus.read_D_L2     = 1'b0;
        bus.write_D_L2    = 1'b0;
        bus.tag_D_L2      = '0;
        bus.index_D_L2    = '0;
        bus.wb_tag_D_L2   = '0;
        bus.wb_index_D_L2 = '0;
        bus.wb_data_D_L2  = '0;
        bus.ready_L2      = 1'b0;
    endtask

    task automatic do_reset();
        nrst = 1'b1;
        step();
        step();
        nrst = 1'b0;
    endtask

    // single I miss: grant, check address and count, then complete
    task automatic i_miss(input string tag, input logic [17:0] t, input logic [7:0] ix,
                          input logic [15:0] exp_cnt);
        bus.read_I_L2  = 1'b1;
        bus.tag_I_L2   = t;
        bus.index_I_L2 = ix;
        step();
        check({tag, "_read"}, 64'(bus.read_L2), 64'd1);
        check({tag, "_tag"}, 64'(bus.tag_L2), 64'(t));
        check({tag, "_cnt_i"}, 64'(bus.gnt_cnt_I), 64'(exp_cnt));
        pulse_ready(tag, 1'b1, 1'b0);
        bus.read_I_L2 = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_rdy_i  = 0;
        n_rdy_d  = 0;
        line_a   = {16{32'hDEADBEEF}};
        line_b   = {16{32'h0BADF00D}};
        clear_inputs();
        do_reset();

        check("rst_busy",  64'(bus.busy), 64'd0);
        check("rst_read",  64'(bus.read_L2), 64'd0);
        check("rst_write", 64'(bus.write_L2), 64'd0);
        check("rst_tag",   64'(bus.tag_L2), 64'd0);
        check("rst_index", 64'(bus.index_L2), 64'd0);
        check("rst_wdata", 64'(bus.wdata_L2 == '0), 64'd1);
        check("rst_cnt_i", 64'(bus.gnt_cnt_I), 64'd0);
        check("rst_cnt_d", 64'(bus.gnt_cnt_D), 64'd0);

        // I-only miss, ready three cycles after read_L2 rises
        bus.read_I_L2  = 1'b1;
        bus.tag_I_L2   = 18'h12345;
        bus.index_I_L2 = 8'h1A;
        step();
        check("i1_read",  64'(bus.read_L2), 64'd1);
        check("i1_write", 64'(bus.write_L2), 64'd0);
        check("i1_tag",   64'(bus.tag_L2), 64'h12345);
        check("i1_index", 64'(bus.index_L2), 64'h1A);
        check("i1_busy",  64'(bus.busy), 64'd1);
        check("i1_cnt_i", 64'(bus.gnt_cnt_I), 64'd1);
        step();
        step();
        check("i1_hold", 64'(bus.read_L2), 64'd1);
        pulse_ready("i1", 1'b1, 1'b0);
        bus.read_I_L2 = 1'b0;
        check("i1_done_busy", 64'(bus.busy), 64'd0);
        check("i1_done_read", 64'(bus.read_L2), 64'd0);
        check("i1_pulses", 64'(n_rdy_i), 64'd1);

        // simultaneous requests after reset: I, then D after one IDLE cycle, then I again
        do_reset();
        bus.read_I_L2  = 1'b1;
        bus.tag_I_L2   = 18'h11111;
        bus.index_I_L2 = 8'h44;
        bus.read_D_L2  = 1'b1;
        bus.tag_D_L2   = 18'h2AAAA;
        bus.index_D_L2 = 8'h33;
        step();
        check("rr1_read", 64'(bus.read_L2), 64'd1);
        check("rr1_tag",  64'(bus.tag_L2), 64'h11111);
        pulse_ready("rr1", 1'b1, 1'b0);
        bus.read_I_L2 = 1'b0;
        check("rr_gap_busy", 64'(bus.busy), 64'd0);
        step();
        check("rr2_read",  64'(bus.read_L2), 64'd1);
        check("rr2_tag",   64'(bus.tag_L2), 64'h2AAAA);
        check("rr2_index", 64'(bus.index_L2), 64'h33);
        pulse_ready("rr2", 1'b0, 1'b1);
        bus.read_I_L2  = 1'b1;
        bus.tag_I_L2   = 18'h0F0F0;
        bus.tag_D_L2   = 18'h25252;
        step();
        check("rr3_tag",   64'(bus.tag_L2), 64'h0F0F0);
        check("rr3_cnt_i", 64'(bus.gnt_cnt_I), 64'd2);
        check("rr3_cnt_d", 64'(bus.gnt_cnt_D), 64'd1);
        pulse_ready("rr3", 1'b1, 1'b0);
        bus.read_I_L2 = 1'b0;
        bus.read_D_L2 = 1'b0;

        // dirty D miss: write-back then refill, one ready_L2_D after the read only
        base_d = n_rdy_d;
        bus.read_D_L2     = 1'b1;
        bus.write_D_L2    = 1'b1;
        bus.tag_D_L2      = 18'h3C3C3;
        bus.index_D_L2    = 8'h05;
        bus.wb_tag_D_L2   = 18'h15555;
        bus.wb_index_D_L2 = 8'h05;
        bus.wb_data_D_L2  = line_a;
        step();
        step();
        check("wb_write", 64'(bus.write_L2), 64'd1);
        check("wb_read",  64'(bus.read_L2), 64'd0);
        check("wb_tag",   64'(bus.tag_L2), 64'h15555);
        check("wb_index", 64'(bus.index_L2), 64'h05);
        bus.wb_data_D_L2 = line_b;
        bus.wb_tag_D_L2  = 18'h00007;
        #1;
        check("wb_data", 64'(bus.wdata_L2 == line_a), 64'd1);
        pulse_ready("wb", 1'b0, 1'b0);
        check("rf_read",  64'(bus.read_L2), 64'd1);
        check("rf_write", 64'(bus.write_L2), 64'd0);
        check("rf_tag",   64'(bus.tag_L2), 64'h3C3C3);
        check("rf_index", 64'(bus.index_L2), 64'h05);
        pulse_ready("rf", 1'b0, 1'b1);
        bus.read_D_L2  = 1'b0;
        bus.write_D_L2 = 1'b0;
        check("rf_busy",   64'(bus.busy), 64'd0);
        check("rf_pulses", 64'(n_rdy_d - base_d), 64'd1);
        check("rf_cnt_d",  64'(bus.gnt_cnt_D), 64'd2);

        // requester address changes while I_RD is pending
        bus.read_I_L2  = 1'b1;
        bus.tag_I_L2   = 18'h00ABC;
        bus.index_I_L2 = 8'h7E;
        step();
        check("cap_tag0", 64'(bus.tag_L2), 64'h00ABC);
        bus.tag_I_L2   = 18'h3FFFF;
        bus.index_I_L2 = 8'h01;
        step();
        check("cap_tag1",   64'(bus.tag_L2), 64'h00ABC);
        check("cap_index1", 64'(bus.index_L2), 64'h7E);
        pulse_ready("cap", 1'b1, 1'b0);
        bus.read_I_L2 = 1'b0;

        // reset in the middle of a write-back
        base_d = n_rdy_d;
        bus.read_D_L2   = 1'b1;
        bus.write_D_L2  = 1'b1;
        bus.tag_D_L2    = 18'h01234;
        bus.wb_tag_D_L2 = 18'h04321;
        step();
        step();
        check("ab_write", 64'(bus.write_L2), 64'd1);
        nrst = 1'b1;
        step();
        check("ab_busy",  64'(bus.busy), 64'd0);
        check("ab_write0", 64'(bus.write_L2), 64'd0);
        check("ab_cnt_i", 64'(bus.gnt_cnt_I), 64'd0);
        check("ab_cnt_d", 64'(bus.gnt_cnt_D), 64'd0);
        clear_inputs();
        nrst = 1'b0;
        step();
        check("ab_pulses", 64'(n_rdy_d - base_d), 64'd0);

        // stray ready_L2 while idle
        base_d = n_rdy_d;
        pulse_ready("idle", 1'b0, 1'b0);
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_pulses", 64'(n_rdy_d - base_d), 64'd0);

        // I grant counter saturation from a forced 16'hFFFE
        force dut.gnt_cnt_I_q = 16'hFFFE;
        step();
        release dut.gnt_cnt_I_q;
        step();
        check("sat_pre", 64'(bus.gnt_cnt_I), 64'hFFFE);
        i_miss("sat1", 18'h00001, 8'h02, 16'hFFFF);
        i_miss("sat2", 18'h00003, 8'h04, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 SHALL have parameter TNUM_2, default 18, meaning L2 tag bits.
REQ-002 SHALL have parameter INUM_2, default 8, meaning L2 index bits.
REQ-003 SHALL have parameter DWIDTH, default 512, meaning cache line width in bits.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge
- nrst  in  1  reset; one clock; reset is synchronous and active-high (nrst=1 resets)
- read_I_L2  in  1  L1_I miss request, held until ready_L2_I
- tag_I_L2 / index_I_L2  in  TNUM_2 / INUM_2  L1_I miss address
- read_D_L2  in  1  L1_D miss request, held until ready_L2_D
- write_D_L2  in  1  L1_D victim dirty; write-back precedes refill; valid with read_D_L2
- tag_D_L2 / index_D_L2  in  TNUM_2 / INUM_2  L1_D miss address
- wb_tag_D_L2 / wb_index_D_L2  in  TNUM_2 / INUM_2  L1_D victim address
- wb_data_D_L2  in  DWIDTH  victim line
- ready_L2  in  1  L2 one-cycle completion pulse for current operation
- read_L2 / write_L2  out  1 / 1  operation strobe to L2, held until ready_L2
- tag_L2 / index_L2  out  TNUM_2 / INUM_2  address to L2
- wdata_L2  out  DWIDTH  write-back data to L2
- ready_L2_I / ready_L2_D  out  1 / 1  completion pulse to L1_I / L1_D
- busy  out  1  state != IDLE
- gnt_cnt_I / gnt_cnt_D  out  16 / 16  saturating grant counters

Function
REQ-005 SHALL implement FSM states IDLE, I_RD, D_WB, D_RD.
REQ-006 SHALL, in IDLE with one requester asserting, grant it at the next edge; no request keeps IDLE.
REQ-007 SHALL, with both requesting in IDLE, grant round-robin: the requester not granted last wins; after reset L1_I wins first.
REQ-008 SHALL enter D_WB when the granted D request has write_D_L2=1, else D_RD; an I grant enters I_RD.
REQ-009 SHALL capture the address (and wb_data_D_L2 for D_WB) in registers at the grant edge; outputs to L2 drive only from those registers, so later requester input changes are ignored.
REQ-010 SHALL assert read_L2=1 in I_RD and D_RD, and write_L2=1 in D_WB, starting the first cycle in state and holding until ready_L2 is sampled; never both at once.
REQ-011 SHALL, on ready_L2 in D_WB, move to D_RD with refill address and drive read_L2 the next cycle; ready_L2_D is not asserted after the write phase.
REQ-012 SHALL drive ready_L2_I (I_RD) or ready_L2_D (D_RD) combinationally equal to ready_L2, one cycle, and return to IDLE at that edge.
REQ-013 SHALL have a minimum one IDLE cycle between grants; a waiting request is granted at the edge ending that IDLE cycle.
REQ-014 SHALL ignore ready_L2 in IDLE; no ready_L2_* pulse results.
REQ-015 SHALL increment gnt_cnt_I / gnt_cnt_D by 1 on each grant edge, saturating at 16'hFFFF.
REQ-016 SHALL never pass a request to L2 while another L2 operation is outstanding.

Reset
REQ-017 SHALL, with nrst=1 at a rising edge, set state IDLE, last-grant to D (L1_I next), all strobes/ready outputs 0, captured tag/index/data 0, counters 0, busy 0.
REQ-018 SHALL let nrst override any mid-transaction state; the aborted operation produces no ready_L2_* pulse, and requesters re-issue after nrst=0.

Verification
REQ-019 SHALL cover: I-only, tag_I=18'h12345 index_I=8'h1A, ready_L2 three cycles after read_L2 -> read_L2=1 with that address, ready_L2_I one pulse, gnt_cnt_I=1.
REQ-020 SHALL cover: read_I_L2 and read_D_L2 same cycle after reset -> I_RD first; D_RD after one IDLE cycle; the next simultaneous pair grants I (round-robin).
REQ-021 SHALL cover: D with write_D_L2=1, wb_index=8'h05, index=8'h05 -> write_L2 with wb_tag/wb_data, then read_L2 with refill tag; exactly one ready_L2_D, after the read.
REQ-022 SHALL cover: tag_I_L2 changed while I_RD pending -> tag_L2 stays at the captured value until ready_L2.
REQ-023 SHALL cover: nrst=1 during D_WB -> next cycle busy=0, write_L2=0, no ready_L2_D, counters 0.
REQ-024 SHALL cover: preload gnt_cnt_I to 16'hFFFE via 2 grants past forced value -> counter holds 16'hFFFF; ready_L2 pulsed in IDLE -> no ready_L2_I/D.
